// File: rtl/seg_display_arbiter.sv
// rtl/seg_display_arbiter.sv - round-robin arbiter sharing a 4-digit seven-segment display between two requesters
`timescale 1ns/1ps
module seg_display_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = $clog2(HOLD_CYCLES)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic [15:0] data0,
   input  logic        req1,
   input  logic [15:0] data1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        owner,
   output logic        busy,
   output logic [3:0]  dig0,
   output logic [3:0]  dig1,
   output logic [3:0]  dig2,
   output logic [3:0]  dig3
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

   state_t            state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [15:0]       digits, digits_n;
   logic              owner_r, owner_n;
   logic              prio, prio_n;   // requester index that wins a simultaneous request
   logic              cur, req_cur, req_oth;
   logic              take, take_idx;

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      digits_n = digits;
      owner_n  = owner_r;
      prio_n   = prio;
      cur      = (state == OWN1);
      req_cur  = cur ? req1 : req0;
      req_oth  = cur ? req0 : req1;
      take     = 1'b0;
      take_idx = 1'b0;

      case (state)
         IDLE: begin
            if (req0 | req1) begin
               take     = 1'b1;
               take_idx = (req0 & req1) ? prio : req1;
            end
         end
         OWN0, OWN1: begin
            if (!req_cur && req_oth) begin
               take     = 1'b1;
               take_idx = ~cur;
            end else if (!req_cur) begin
               state_n = IDLE;
            end else if (cnt == CNT_MAX && req_oth) begin
               take     = 1'b1;
               take_idx = ~cur;
            end else begin
               cnt_n    = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
               digits_n = cur ? data1 : data0;
            end
         end
         default: state_n = IDLE;
      endcase

      // Every new grant restarts the quantum and loads the new owner's digits.
      if (take) begin
         state_n  = take_idx ? OWN1 : OWN0;
         cnt_n    = '0;
         digits_n = take_idx ? data1 : data0;
         owner_n  = take_idx;
         prio_n   = ~take_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         digits  <= '0;
         owner_r <= 1'b0;
         prio    <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         digits  <= digits_n;
         owner_r <= owner_n;
         prio    <= prio_n;
      end
   end

   assign gnt0  = (state == OWN0);
   assign gnt1  = (state == OWN1);
   assign busy  = (state == OWN0) || (state == OWN1);
   assign owner = owner_r;
   assign dig0  = digits[3:0];
   assign dig1  = digits[7:4];
   assign dig2  = digits[11:8];
   assign dig3  = digits[15:12];

endmodule
